// File: rtl/lut_chk_pkg.sv
// Shared types and helpers for the P-LUT sweep self-test sequencer.
package lut_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Index of the last pattern in an exhaustive sweep of an n-input netlist.
  function automatic int unsigned sweep_last(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Width of a counter that must hold 2^n without wrapping.
  function automatic int unsigned cnt_w(input int unsigned n);
    return n + 32'd1;
  endfunction

endpackage

// File: rtl/lut_chk_cmp.sv
// Compare/record stage: registers the netlist output for each issued
// pattern, checks it one cycle later against the golden ROM word, counts
// mismatches and captures the first failing pattern.
module lut_chk_cmp
  import lut_chk_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 10,
  parameter int unsigned OUT_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          cmp_v,
  input  logic                          hold,
  input  logic [N_INPUTS-1:0]           idx,
  input  logic [OUT_WIDTH-1:0]          f_i,
  input  logic [OUT_WIDTH-1:0]          exp_data_i,
  output logic                          mismatch,
  output logic [cnt_w(N_INPUTS)-1:0]    err_count,
  output logic [N_INPUTS-1:0]           first_err_idx,
  output logic [OUT_WIDTH-1:0]          first_err_got,
  output logic [OUT_WIDTH-1:0]          first_err_exp
);

  localparam int unsigned CNT_W = cnt_w(N_INPUTS);

  logic                 cmp_q;
  logic [OUT_WIDTH-1:0] f_q;
  logic [N_INPUTS-1:0]  idx_q;

  // The golden word arrives one cycle after its address, so the netlist
  // output is delayed by one register to line up with it.
  assign mismatch = cmp_q && (f_q != exp_data_i);

  // Capture pipeline, error counter and first-failure record.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cmp_q         <= 1'b0;
      f_q           <= '0;
      idx_q         <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      cmp_q <= cmp_v;
      if (cmp_v) begin
        f_q   <= f_i;
        idx_q <= idx;
      end
      if (mismatch && !hold) begin
        err_count <= err_count + CNT_W'(1);
        if (err_count == '0) begin
          first_err_idx <= idx_q;
          first_err_got <= f_q;
          first_err_exp <= exp_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive self-test sequencer for a combinational P-LUT netlist: drives
// every input pattern, compares each output with a golden ROM word and
// reports a pass/fail summary with the first failing pattern.
module lut_sweep_checker
  import lut_chk_pkg::*;
#(
  parameter int unsigned N_INPUTS     = 10,
  parameter int unsigned OUT_WIDTH    = 11,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [N_INPUTS-1:0]           x_o,
  input  logic [OUT_WIDTH-1:0]          f_i,
  output logic [N_INPUTS-1:0]           exp_addr_o,
  input  logic [OUT_WIDTH-1:0]          exp_data_i,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [cnt_w(N_INPUTS)-1:0]    err_count,
  output logic [N_INPUTS-1:0]           first_err_idx,
  output logic [OUT_WIDTH-1:0]          first_err_got,
  output logic [OUT_WIDTH-1:0]          first_err_exp
);

  localparam logic [N_INPUTS-1:0] LAST = N_INPUTS'(sweep_last(N_INPUTS));

  state_t              state, state_n;
  logic [N_INPUTS-1:0] idx;
  logic                accept;
  logic                issue;
  logic                cancel;
  logic                mismatch;

  assign x_o        = idx;
  assign exp_addr_o = idx;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign cancel     = busy && abort;

  // Next-state logic; a pattern is only issued for comparison when the
  // sweep is continuing, so an early stop or abort discards it.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (STOP_ON_FAIL && mismatch) begin
          state_n = DONE;
        end else begin
          issue = 1'b1;
          if (idx == LAST) state_n = DRAIN;
        end
      end
      DRAIN: state_n = abort ? IDLE : DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, pattern index and held pass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx <= '0;
      end else if (issue && idx != LAST) begin
        idx <= idx + N_INPUTS'(1);
      end
      // The final compare may still be landing this cycle, so it is
      // folded into the verdict directly rather than via err_count.
      if (accept || cancel) begin
        pass <= 1'b0;
      end else if (state != DONE && state_n == DONE) begin
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

  lut_chk_cmp #(
    .N_INPUTS (N_INPUTS),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .cmp_v        (issue),
    .hold         (cancel),
    .idx          (idx),
    .f_i          (f_i),
    .exp_data_i   (exp_data_i),
    .mismatch     (mismatch),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .first_err_got(first_err_got),
    .first_err_exp(first_err_exp)
  );

endmodule

// File: doc/lut_sweep_checker.md
Name: lut_sweep_checker

Overview:
- Hardware self-test sequencer for a synthesized combinational P-LUT netlist (`top`: `x` in, `f` out).
- Sweeps every input pattern 0..2^N_INPUTS-1 into the netlist and registers its output.
- Compares each output against a golden truth-table word read from a synchronous ROM, counts mismatches and records the first failure.
- Sits beside the netlist on-chip or in FPGA bring-up, replacing the simulation-only exhaustive check.

Parameters:
- N_INPUTS, 10, netlist input width; sweep length is 2^N_INPUTS.
- OUT_WIDTH, 11, netlist output width and golden word width.
- STOP_ON_FAIL, 1, 1 = end the run at the first mismatch; 0 = sweep all patterns.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel a sweep in progress.
- x_o  out  N_INPUTS  pattern driven to netlist `x`.
- f_i  in  OUT_WIDTH  netlist output `f`, combinational from x_o.
- exp_addr_o  out  N_INPUTS  golden ROM address; always equals x_o.
- exp_data_i  in  OUT_WIDTH  golden word, valid 1 cycle after exp_addr_o.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  1-cycle pulse at sweep end.
- pass  out  1  held result of the last completed sweep.
- err_count  out  N_INPUTS+1  mismatches in the current or last sweep.
- first_err_idx  out  N_INPUTS  pattern index of the first mismatch.
- first_err_got  out  OUT_WIDTH  netlist value at the first mismatch.
- first_err_exp  out  OUT_WIDTH  golden value at the first mismatch.

Behaviour:
- Reset values: x_o, exp_addr_o, err_count, first_err_* all 0; busy, done, pass all 0; state IDLE.

States:
- IDLE
  - start=1 and abort=0 -> RUN. idx, err_count and first_err_* clear. pass clears.
  - start while abort=1 is ignored.
- RUN
  - x_o = idx; idx increments each cycle.
  - At idx = 2^N-1 -> DRAIN; idx does not wrap.
- DRAIN
  - One cycle; completes the final compare -> DONE.
- DONE
  - done=1 for exactly 1 cycle -> IDLE.
  - pass = (err_count_final == 0).

Compare stage:
- One-cycle-delayed valid flag cmp_v.
- f_q <= f_i and idx_q <= idx at every RUN edge.
- In the following cycle, compare f_q against exp_data_i.
- On mismatch:
  - err_count += 1. Width N_INPUTS+1 holds 2^N without overflow; no saturation logic.
  - If first mismatch: latch idx_q, f_q and exp_data_i into first_err_*.
- A compare whose cmp_v is asserted is evaluated even in the cycle the FSM leaves RUN.

Latency (STOP_ON_FAIL=0, or no error):
- start sampled at edge 0; x_o=0 during cycle 1; x_o=2^N-1 during cycle 2^N.
- DRAIN in cycle 2^N+1; done during cycle 2^N+2 (cycle 1026 at default).

STOP_ON_FAIL=1:
- A mismatch detected in compare cycle c moves to DONE in cycle c+1, skipping DRAIN.
- err_count = 1 and pass = 0.
- The pattern already issued in cycle c is discarded; it is not compared.

Boundary conditions:
- start while busy: ignored.
- abort in RUN/DRAIN: IDLE next cycle. No done pulse. pass=0. err_count and first_err_* frozen at current values.
- abort in IDLE/DONE: no effect; the done pulse still occurs.
- rst mid-sweep: all outputs return to reset values next cycle.
- x_o holds its last value when not in RUN.
- Back-to-back start in the IDLE cycle right after DONE: accepted.

Decomposition:
- Package `lut_chk_pkg`:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - function sweep_last(N) = 2^N-1.
  - localparam CNT_W(N) = N+1.
- Sub-module `lut_chk_cmp`:
  - Compare/record stage: f_q, idx_q, cmp_v, err_count, first_err_* capture.
  - Inputs: clear, cmp_v. Output: mismatch strobe to the FSM.
- FSM and index counter stay in lut_sweep_checker.

Test Plan:
1. N_INPUTS=4, OUT_WIDTH=3, netlist model f=x[2:0], ROM identical; pulse start.
   -> x_o steps 0..15, done at cycle 18, pass=1, err_count=0.
2. Same setup, ROM word 9 = 3'b000 (true 3'b001), STOP_ON_FAIL=1.
   -> done at cycle 12; err_count=1; first_err_idx=9, got=1, exp=0; pass=0.
3. Same setup with STOP_ON_FAIL=0, ROM words 0 and 15 corrupted.
   -> full sweep, done at cycle 18; err_count=2; first_err_idx=0; pass=0.
   -> Covers the first and last compare, including the DRAIN-cycle compare.
4. Default parameters, ROM loaded with the released 11264-bit truth table, real `top` netlist.
   -> done at cycle 1026, pass=1, err_count=0.
5. abort at cycle 7 of a run; start asserted again in cycles 3–5.
   -> busy drops in cycle 8, no done pulse, pass=0; the extra starts are ignored.
   -> A new start afterwards sweeps cleanly.
6. rst asserted at cycle 5 of a run.
   -> Next cycle all outputs are 0 and state is IDLE.
   -> start in IDLE together with abort=1 stays in IDLE.
